mem_test_sequencer: RTL and testbench
=====================================

Name: mem_test_sequencer

Overview:
Parametrised successor to the memory-checker command controller. It generates a stream of read/write memory commands from a latched test configuration and drives them through a valid/ready interface to the transaction block. Compared with the previous controller it adds:
- widths set by parameters;
- INC-with-stride and DEC address modes;
- a block write-then-read test mode;
- abort;
- an accepted-command counter.

Parameters:
ADDR_W, 32, command address width (word address)
CNT_W, 16, test count width
BURST_W, 11, burstcount width
LFSR_W, 32, random-address LFSR width; must be >= ADDR_W (elaboration error otherwise)

Ports:
clk_i  in  1  clock
rst_i  in  1  reset
start_i  in  1  start pulse, honoured only in IDLE
abort_i  in  1  stop issuing, drain, finish
test_mode_i  in  2  test_mode_t
addr_mode_i  in  3  addr_mode_t
count_i  in  CNT_W  commands (WR_ONLY/RD_ONLY) or pairs (WR_CHECK/BLOCK)
base_addr_i  in  ADDR_W  FIX address / INC,DEC start / RND seed
stride_i  in  ADDR_W  INC/DEC step
burst_i  in  BURST_W  burstcount copied onto every command
err_i  in  1  error from compare block
busy_i  in  1  OR of downstream busy flags
cmd_valid_o  out  1  command valid
cmd_ready_i  in  1  downstream accepts
cmd_write_o  out  1  1 = write, 0 = read
cmd_addr_o  out  ADDR_W  command address
cmd_burst_o  out  BURST_W  command burstcount
busy_o  out  1  state != IDLE
done_o  out  1  one-cycle pulse at test end
error_o  out  1  sticky, set by err_i, cleared on start
aborted_o  out  1  sticky, set by abort_i, cleared on start
issued_cnt_o  out  CNT_W+1  accepted-command count, cleared on start

Behaviour:
- Reset is rst_i, asynchronous, active-high; the clock is clk_i.
- Reset values: all outputs 0, state IDLE.
- Configuration:
  - All *_i configuration is latched on the edge where start_i=1 in IDLE.
  - Configuration changes later in the test have no effect.
- States: IDLE, ISSUE, ISSUE_RD, DRAIN.
- IDLE + start_i:
  - count_i == 0: go to DRAIN; no command is ever issued.
  - otherwise: go to ISSUE; cmd_valid_o=1 with the first command on that same edge, so valid is visible the cycle after start.
- Handshake:
  - Accept = cmd_valid_o && cmd_ready_i.
  - While valid && !ready, all cmd_* outputs hold stable.
  - On accept the next command is loaded on the same edge, so back-to-back accepts give one command per cycle.
  - cmd_valid_o drops on the edge of the final accept.
- WR_ONLY (0) / RD_ONLY (1): count commands, address advances after each accept.
- WR_CHECK (2):
  - Sequence is W a0, R a0, W a1, R a1, …; 2*count commands in total.
  - Address advances only after a read accept.
- BLOCK (3):
  - ISSUE writes a0..a(N-1).
  - The address generator then restarts from its initial value, the state moves to ISSUE_RD, and reads a0..a(N-1) follow.
  - The first read is presented on the edge of the last write accept, with no bubble.
- Test mode value 3 is BLOCK; unknown addr_mode values (6, 7) behave as FIX.
- Address modes (first address / next address):
  - FIX (0): base / unchanged.
  - RND (1):
    - LFSR_W Galois LFSR with the package tap constant.
    - Seed = base zero-extended; a zero seed is replaced by all-ones.
    - Address = lfsr[ADDR_W-1:0].
  - RUN_0 (2): all-ones with bit0=0 / rotate left by 1.
  - RUN_1 (3): one-hot bit0 / rotate left by 1.
  - INC (4): base / +stride, mod 2^ADDR_W wrap.
  - DEC (5): base / -stride, mod 2^ADDR_W wrap.
- Counters:
  - The internal remaining counter is CNT_W wide; the last-command flag is registered, not a compare on the output path.
  - issued_cnt_o increments on every accept and saturates at its maximum value.
- err_i or abort_i in any non-IDLE state:
  - On the next edge, cmd_valid_o=0, state goes to DRAIN, and error_o/aborted_o are set (both are set if both inputs are high).
  - An accept on that same edge still counts in issued_cnt_o.
  - Both inputs are ignored in IDLE.
- DRAIN: when busy_i=0, go to IDLE with done_o=1 for one cycle.
- start_i outside IDLE is ignored.
- Reset mid-test returns everything to reset values immediately; cmd_valid_o drops asynchronously.

Decomposition:
- Package settings_pkg holds:
  - test_mode_t and addr_mode_t enums;
  - the LFSR tap constant (function of LFSR_W);
  - the state enum.
- Sub-module mem_test_addr_gen (ADDR_W, LFSR_W):
  - Inputs: load (cfg + base + stride), next, restart.
  - Output: registered addr.
  - restart reproduces the sequence from load exactly.

Test Plan:
- WR_ONLY, INC, base=0x100, stride=4, count=3, ready always 1 -> writes at 0x100, 0x104, 0x108 on consecutive cycles; done_o 1 cycle after busy_i falls; issued_cnt_o=3.
- WR_CHECK, FIX, base=0x20, count=2, ready toggling 1/0 -> W20, R20, W20, R20; payload stable during ready=0 stalls; 4 accepts.
- BLOCK, RND, seed=0, count=4 -> 4 writes then 4 reads on an identical address list; first LFSR state = all-ones.
- DEC, base=0x2, stride=3, count=2 -> addresses 0x2 then 0xFFFFFFFF (wrap).
- err_i pulsed after 5 accepts of count=10, busy_i held 3 more cycles -> cmd_valid_o low next cycle; error_o=1; issued_cnt_o=5 (6 if accept coincides); done_o after busy_i clears.
- count=0 start -> no cmd_valid_o; done_o once busy_i=0. start_i during ISSUE -> ignored. rst_i mid-burst -> all outputs 0.

Source files
------------

// File: rtl/settings_pkg.sv
// Shared types and constants for the memory test sequencer.
package settings_pkg;

    typedef enum logic [1:0] {
        TM_WR_ONLY  = 2'd0,
        TM_RD_ONLY  = 2'd1,
        TM_WR_CHECK = 2'd2,
        TM_BLOCK    = 2'd3
    } test_mode_t;

    // Encodings 6 and 7 are unused and fall back to fixed addressing.
    typedef enum logic [2:0] {
        AM_FIX   = 3'd0,
        AM_RND   = 3'd1,
        AM_RUN_0 = 3'd2,
        AM_RUN_1 = 3'd3,
        AM_INC   = 3'd4,
        AM_DEC   = 3'd5
    } addr_mode_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ISSUE    = 2'd1,
        ST_ISSUE_RD = 2'd2,
        ST_DRAIN    = 2'd3
    } state_t;

    // Right-shifting Galois LFSR toggle mask; bit k set means tap k+1.
    // Widths outside the table get a simple top-bit/bottom-bit mask that is
    // not guaranteed maximal length.
    function automatic logic [63:0] lfsr_taps(input int width);
        case (width)
            8:       return 64'h0000_0000_0000_00B8;
            16:      return 64'h0000_0000_0000_B400;
            24:      return 64'h0000_0000_00E1_0000;
            32:      return 64'h0000_0000_8020_0003;
            64:      return 64'hD800_0000_0000_0000;
            default: return (64'd1 << (width - 1)) | 64'd1;
        endcase
    endfunction

endpackage

// File: rtl/mem_test_addr_gen.sv
// Address generator: loads a mode/base/stride, steps on next, and replays
// the identical sequence from its first address on restart.
module mem_test_addr_gen
    import settings_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LFSR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load,
    input  logic              next,
    input  logic              restart,
    input  addr_mode_t        mode,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] stride,
    output logic [ADDR_W-1:0] addr
);

    if (LFSR_W < ADDR_W) begin : g_width_check
        $error("mem_test_addr_gen: LFSR_W must be >= ADDR_W");
    end

    localparam logic [63:0]       TAPS_FULL = lfsr_taps(LFSR_W);
    localparam logic [LFSR_W-1:0] TAPS      = TAPS_FULL[LFSR_W-1:0];

    addr_mode_t        mode_q;
    addr_mode_t        sel_mode;
    logic [ADDR_W-1:0] base_q, stride_q, sel_base;
    logic [ADDR_W-1:0] addr_q, init_addr, step_addr;
    logic [LFSR_W-1:0] lfsr_q, seed, init_lfsr, step_lfsr;

    assign addr = addr_q;

    // First address comes from the fresh inputs on load, from the saved copy on restart.
    always_comb begin
        sel_mode  = load ? mode : mode_q;
        sel_base  = load ? base : base_q;
        seed      = LFSR_W'(sel_base);
        init_lfsr = (seed == '0) ? '1 : seed;
        step_lfsr = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);
        case (sel_mode)
            AM_RND:   init_addr = init_lfsr[ADDR_W-1:0];
            AM_RUN_0: init_addr = {{(ADDR_W-1){1'b1}}, 1'b0};
            AM_RUN_1: init_addr = ADDR_W'(1);
            default:  init_addr = sel_base;
        endcase
        case (mode_q)
            AM_RND:   step_addr = step_lfsr[ADDR_W-1:0];
            AM_RUN_0,
            AM_RUN_1: step_addr = {addr_q[ADDR_W-2:0], addr_q[ADDR_W-1]};
            AM_INC:   step_addr = addr_q + stride_q;
            AM_DEC:   step_addr = addr_q - stride_q;
            default:  step_addr = addr_q;
        endcase
    end

    // Configuration copy plus the live address/LFSR registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mode_q   <= AM_FIX;
            base_q   <= '0;
            stride_q <= '0;
            addr_q   <= '0;
            lfsr_q   <= '0;
        end else begin
            if (load) begin
                mode_q   <= mode;
                base_q   <= base;
                stride_q <= stride;
            end
            if (load || restart) begin
                addr_q <= init_addr;
                lfsr_q <= init_lfsr;
            end else if (next) begin
                addr_q <= step_addr;
                lfsr_q <= step_lfsr;
            end
        end
    end

endmodule

// File: rtl/mem_test_sequencer.sv
// Memory test sequencer: turns a latched test configuration into a stream
// of read/write commands for the transaction block.
//
// Command handshake: a command transfers on every rising edge where
// cmd_valid_o && cmd_ready_i. While valid is high and ready is low, every
// cmd_* output holds. The next command is loaded on the accepting edge,
// so a continuously ready sink receives one command per cycle.
module mem_test_sequencer
    import settings_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int CNT_W   = 16,
    parameter int BURST_W = 11,
    parameter int LFSR_W  = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               abort_i,
    input  logic [1:0]         test_mode_i,
    input  logic [2:0]         addr_mode_i,
    input  logic [CNT_W-1:0]   count_i,
    input  logic [ADDR_W-1:0]  base_addr_i,
    input  logic [ADDR_W-1:0]  stride_i,
    input  logic [BURST_W-1:0] burst_i,
    input  logic               err_i,
    input  logic               busy_i,
    output logic               cmd_valid_o,
    input  logic               cmd_ready_i,
    output logic               cmd_write_o,
    output logic [ADDR_W-1:0]  cmd_addr_o,
    output logic [BURST_W-1:0] cmd_burst_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               error_o,
    output logic               aborted_o,
    output logic [CNT_W:0]     issued_cnt_o
);

    // state_q is the observable FSM state for checkers.
    state_t             state_q, state_d;
    test_mode_t         tm_q, tm_in;
    logic [CNT_W-1:0]   count_q, rem_q, rem_d;
    logic [BURST_W-1:0] burst_q;
    logic               valid_q, valid_d, write_q, write_d;
    logic               last_q, last_d, done_q, done_d;
    logic               error_q, aborted_q;
    logic [CNT_W:0]     issued_q;
    logic               accept, stop, start_cfg, finish;
    logic               ag_next, ag_restart;

    assign tm_in  = test_mode_t'(test_mode_i);
    assign accept = valid_q & cmd_ready_i;
    assign stop   = err_i | abort_i;

    assign cmd_valid_o  = valid_q;
    assign cmd_write_o  = write_q;
    assign cmd_burst_o  = burst_q;
    assign busy_o       = (state_q != ST_IDLE);
    assign done_o       = done_q;
    assign error_o      = error_q;
    assign aborted_o    = aborted_q;
    assign issued_cnt_o = issued_q;

    mem_test_addr_gen #(
        .ADDR_W (ADDR_W),
        .LFSR_W (LFSR_W)
    ) u_addr_gen (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load    (start_cfg),
        .next    (ag_next),
        .restart (ag_restart),
        .mode    (addr_mode_t'(addr_mode_i)),
        .base    (base_addr_i),
        .stride  (stride_i),
        .addr    (cmd_addr_o)
    );

    // Next-state and command sequencing; last_q marks the final command (or pair) of a phase.
    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        write_d    = write_q;
        rem_d      = rem_q;
        last_d     = last_q;
        done_d     = 1'b0;
        start_cfg  = 1'b0;
        finish     = 1'b0;
        ag_next    = 1'b0;
        ag_restart = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    start_cfg = 1'b1;
                    rem_d     = count_i;
                    last_d    = (count_i == CNT_W'(1));
                    write_d   = (tm_in != TM_RD_ONLY);
                    if (count_i == '0) begin
                        state_d = ST_DRAIN;
                        valid_d = 1'b0;
                    end else begin
                        state_d = ST_ISSUE;
                        valid_d = 1'b1;
                    end
                end
            end
            ST_ISSUE, ST_ISSUE_RD: begin
                if (accept) begin
                    case (tm_q)
                        TM_WR_CHECK: begin
                            if (write_q) begin
                                write_d = 1'b0;
                            end else if (last_q) begin
                                finish = 1'b1;
                            end else begin
                                write_d = 1'b1;
                                ag_next = 1'b1;
                                rem_d   = rem_q - 1'b1;
                                last_d  = (rem_q == CNT_W'(2));
                            end
                        end
                        TM_BLOCK: begin
                            if (last_q && state_q == ST_ISSUE) begin
                                ag_restart = 1'b1;
                                state_d    = ST_ISSUE_RD;
                                write_d    = 1'b0;
                                rem_d      = count_q;
                                last_d     = (count_q == CNT_W'(1));
                            end else if (last_q) begin
                                finish = 1'b1;
                            end else begin
                                ag_next = 1'b1;
                                rem_d   = rem_q - 1'b1;
                                last_d  = (rem_q == CNT_W'(2));
                            end
                        end
                        default: begin
                            if (last_q) begin
                                finish = 1'b1;
                            end else begin
                                ag_next = 1'b1;
                                rem_d   = rem_q - 1'b1;
                                last_d  = (rem_q == CNT_W'(2));
                            end
                        end
                    endcase
                end
                if (finish || stop) begin
                    valid_d = 1'b0;
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!busy_i) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM and command payload registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            write_q <= 1'b0;
            rem_q   <= '0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            write_q <= write_d;
            rem_q   <= rem_d;
            last_q  <= last_d;
            done_q  <= done_d;
        end
    end

    // Configuration latched only on an accepted start.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tm_q    <= TM_WR_ONLY;
            count_q <= '0;
            burst_q <= '0;
        end else if (start_cfg) begin
            tm_q    <= tm_in;
            count_q <= count_i;
            burst_q <= burst_i;
        end
    end

    // Sticky status flags and the saturating accepted-command counter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            error_q   <= 1'b0;
            aborted_q <= 1'b0;
            issued_q  <= '0;
        end else if (start_cfg) begin
            error_q   <= 1'b0;
            aborted_q <= 1'b0;
            issued_q  <= '0;
        end else begin
            if (state_q != ST_IDLE) begin
                if (err_i)   error_q   <= 1'b1;
                if (abort_i) aborted_q <= 1'b1;
            end
            if (accept && issued_q != '1) issued_q <= issued_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_test_sequencer.sv
// Bench for mem_test_sequencer: a transaction-level model predicts the
// command list and status flags, and a per-cycle compare checks the DUT.
module tb_mem_test_sequencer;
    import settings_pkg::*;

    localparam int ADDR_W  = 32;
    localparam int CNT_W   = 16;
    localparam int BURST_W = 11;
    localparam int LFSR_W  = 32;
    localparam int W       = ADDR_W + 1;

    // ---------------- clock / reset / DUT ----------------
    logic clk = 1'b0;
    logic rst_i = 1'b1;
    always #5 clk = ~clk;

    logic               start_i = 0, abort_i = 0, err_i = 0, busy_i = 0, cmd_ready_i = 1;
    logic [1:0]         test_mode_i = 0;
    logic [2:0]         addr_mode_i = 0;
    logic [CNT_W-1:0]   count_i = 0;
    logic [ADDR_W-1:0]  base_addr_i = 0, stride_i = 0;
    logic [BURST_W-1:0] burst_i = 0;
    logic               cmd_valid_o, cmd_write_o, busy_o, done_o, error_o, aborted_o;
    logic [ADDR_W-1:0]  cmd_addr_o;
    logic [BURST_W-1:0] cmd_burst_o;
    logic [CNT_W:0]     issued_cnt_o;

    mem_test_sequencer #(
        .ADDR_W(ADDR_W), .CNT_W(CNT_W), .BURST_W(BURST_W), .LFSR_W(LFSR_W)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
        .test_mode_i(test_mode_i), .addr_mode_i(addr_mode_i), .count_i(count_i),
        .base_addr_i(base_addr_i), .stride_i(stride_i), .burst_i(burst_i),
        .err_i(err_i), .busy_i(busy_i), .cmd_valid_o(cmd_valid_o),
        .cmd_ready_i(cmd_ready_i), .cmd_write_o(cmd_write_o), .cmd_addr_o(cmd_addr_o),
        .cmd_burst_o(cmd_burst_o), .busy_o(busy_o), .done_o(done_o),
        .error_o(error_o), .aborted_o(aborted_o), .issued_cnt_o(issued_cnt_o)
    );

    // ---------------- scoreboard state ----------------
    int total = 0;
    int bad   = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] acc_log[$];
    bit               m_busy = 0, m_running = 0, m_done = 0, m_err = 0, m_abort = 0;
    logic [CNT_W:0]   m_issued = '0;
    logic [BURST_W-1:0] m_burst = '0;
    int done_cnt   = 0;
    int ready_mode = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    function automatic logic [31:0] rotl(input logic [31:0] x, input int k);
        return (x << k) | (x >> (32 - k));
    endfunction

    // Expected command list straight from the address-mode and test-mode rules.
    task automatic build_queue(input int tm, input int am, input int cnt,
                               input logic [31:0] base, input logic [31:0] stride);
        logic [31:0] a[$];
        logic [63:0] tf;
        logic [31:0] taps, l;
        tf   = lfsr_taps(LFSR_W);
        taps = tf[31:0];
        l    = (base == 32'h0) ? 32'hFFFF_FFFF : base;
        for (int i = 0; i < cnt; i++) begin
            case (am)
                1: begin a.push_back(l); l = (l >> 1) ^ (l[0] ? taps : 32'h0); end
                2: a.push_back(rotl(32'hFFFF_FFFE, i % 32));
                3: a.push_back(rotl(32'h0000_0001, i % 32));
                4: a.push_back(base + stride * 32'(i));
                5: a.push_back(base - stride * 32'(i));
                default: a.push_back(base);
            endcase
        end
        case (tm)
            0: foreach (a[i]) exp_q.push_back({1'b1, a[i]});
            1: foreach (a[i]) exp_q.push_back({1'b0, a[i]});
            2: foreach (a[i]) begin
                   exp_q.push_back({1'b1, a[i]});
                   exp_q.push_back({1'b0, a[i]});
               end
            default: begin
                foreach (a[i]) exp_q.push_back({1'b1, a[i]});
                foreach (a[i]) exp_q.push_back({1'b0, a[i]});
            end
        endcase
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        bit was_running;
        if (rst_i) begin
            m_busy = 0; m_running = 0; m_done = 0; m_err = 0; m_abort = 0;
            m_issued = '0; m_burst = '0;
            exp_q.delete();
        end else begin
            check("busy", busy_o, m_busy);
            check("done", done_o, m_done);
            check("valid", cmd_valid_o, m_running);
            check("issued", issued_cnt_o, m_issued);
            check("error", error_o, m_err);
            check("aborted", aborted_o, m_abort);
            if (cmd_valid_o && m_running) begin
                check("cmd", {cmd_write_o, cmd_addr_o}, exp_q[0]);
                check("burst", cmd_burst_o, m_burst);
            end
            if (done_o) done_cnt++;
            m_done      = 0;
            was_running = m_running;
            if (!m_busy) begin
                if (start_i) begin
                    exp_q.delete();
                    acc_log.delete();
                    m_issued = '0; m_err = 0; m_abort = 0;
                    m_burst  = burst_i;
                    build_queue(int'(test_mode_i), int'(addr_mode_i), int'(count_i),
                                base_addr_i, stride_i);
                    m_busy    = 1;
                    m_running = (exp_q.size() > 0);
                end
            end else begin
                if (m_running && cmd_ready_i) begin
                    acc_log.push_back(exp_q.pop_front());
                    if (m_issued != '1) m_issued = m_issued + 1'b1;
                    if (exp_q.size() == 0) m_running = 0;
                end
                if (err_i)   begin m_err = 1;   m_running = 0; end
                if (abort_i) begin m_abort = 1; m_running = 0; end
                if (!was_running && !busy_i) begin
                    m_busy = 0;
                    m_done = 1;
                end
            end
        end
    end

    // ---------------- ready driver ----------------
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       cmd_ready_i = 1'b1;
            1:       cmd_ready_i = ~cmd_ready_i;
            default: cmd_ready_i = 1'($urandom_range(0, 1));
        endcase
    end

    // ---------------- driver tasks ----------------
    task automatic start_cfg(input int tm, input int am, input int cnt,
                             input logic [31:0] base, input logic [31:0] stride, input int burst);
        @(posedge clk); #1;
        test_mode_i = tm[1:0];
        addr_mode_i = am[2:0];
        count_i     = cnt[CNT_W-1:0];
        base_addr_i = base;
        stride_i    = stride;
        burst_i     = burst[BURST_W-1:0];
        busy_i      = 1'b1;
        start_i     = 1'b1;
        done_cnt    = 0;
        @(posedge clk); #1;
        start_i     = 1'b0;
        test_mode_i = 2'($urandom_range(0, 3));
        addr_mode_i = 3'($urandom_range(0, 7));
        count_i     = CNT_W'($urandom_range(1, 50));
        base_addr_i = $urandom;
        stride_i    = $urandom;
        burst_i     = BURST_W'($urandom_range(0, 2047));
    endtask

    task automatic finish_test(input int hold);
        int i;
        for (i = 0; i < 400; i++) begin
            if (!m_running) break;
            @(posedge clk); #1;
        end
        if (i == 400) timeout_fail("issue_end");
        repeat (hold) begin @(posedge clk); #1; end
        busy_i = 1'b0;
        for (i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (!busy_o) break;
        end
        if (i == 20) timeout_fail("drain_end");
        @(posedge clk); #1;
    endtask

    // ---------------- directed tests ----------------
    initial begin
        int i;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", cmd_valid_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_issued", issued_cnt_o, 0);
        check("rst_addr", cmd_addr_o, 0);
        rst_i = 1'b0;

        // WR_ONLY, INC, stride 4
        ready_mode = 0;
        start_cfg(0, 4, 3, 32'h100, 32'h4, 5);
        finish_test(2);
        check("t1_len", acc_log.size(), 3);
        check("t1_a0", acc_log[0], {1'b1, 32'h100});
        check("t1_a1", acc_log[1], {1'b1, 32'h104});
        check("t1_a2", acc_log[2], {1'b1, 32'h108});
        check("t1_issued", issued_cnt_o, 3);
        check("t1_done", done_cnt, 1);

        // WR_CHECK, FIX, toggling ready, with an ignored start mid-test
        ready_mode = 1;
        start_cfg(2, 0, 2, 32'h20, 32'h0, 7);
        @(posedge clk); #1;
        test_mode_i = 2'd0; count_i = 16'd9; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        finish_test(1);
        check("t2_len", acc_log.size(), 4);
        check("t2_a0", acc_log[0], {1'b1, 32'h20});
        check("t2_a1", acc_log[1], {1'b0, 32'h20});
        check("t2_a2", acc_log[2], {1'b1, 32'h20});
        check("t2_a3", acc_log[3], {1'b0, 32'h20});
        check("t2_issued", issued_cnt_o, 4);

        // BLOCK, RND, zero seed, random ready
        ready_mode = 2;
        start_cfg(3, 1, 4, 32'h0, 32'h0, 3);
        finish_test(0);
        check("t3_len", acc_log.size(), 8);
        check("t3_w0", acc_log[0], {1'b1, 32'hFFFF_FFFF});
        check("t3_w1", acc_log[1], {1'b1, 32'hFFDF_FFFC});
        check("t3_r0", acc_log[4], {1'b0, 32'hFFFF_FFFF});
        for (int k = 0; k < 4; k++) check("t3_rw_same", acc_log[k + 4][31:0], acc_log[k][31:0]);

        // DEC wrap
        ready_mode = 0;
        start_cfg(0, 5, 2, 32'h2, 32'h3, 1);
        finish_test(0);
        check("t4_a0", acc_log[0], {1'b1, 32'h2});
        check("t4_a1", acc_log[1], {1'b1, 32'hFFFF_FFFF});

        // RD_ONLY walking one, walking zero, unknown mode as FIX
        start_cfg(1, 3, 3, 32'h0, 32'h0, 2);
        finish_test(0);
        check("t5_a2", acc_log[2], {1'b0, 32'h4});
        start_cfg(1, 2, 2, 32'h0, 32'h0, 2);
        finish_test(0);
        check("t6_a1", acc_log[1], {1'b0, 32'hFFFF_FFFD});
        start_cfg(0, 6, 2, 32'h55, 32'h9, 2);
        finish_test(0);
        check("t7_a1", acc_log[1], {1'b1, 32'h55});

        // err_i after five accepts; the coinciding accept counts
        start_cfg(0, 4, 10, 32'h0, 32'h1, 4);
        for (i = 0; i < 50; i++) begin
            if (issued_cnt_o == 5) break;
            @(posedge clk); #1;
        end
        if (i == 50) timeout_fail("err_wait");
        err_i = 1'b1;
        @(posedge clk); #1;
        err_i = 1'b0;
        check("err_valid", cmd_valid_o, 0);
        check("err_flag", error_o, 1);
        check("err_issued", issued_cnt_o, 6);
        repeat (3) begin @(posedge clk); #1; end
        check("err_busy_hold", busy_o, 1);
        finish_test(0);
        check("err_done", done_cnt, 1);

        // abort during BLOCK writes
        start_cfg(3, 0, 4, 32'h80, 32'h0, 2);
        @(posedge clk); #1;
        abort_i = 1'b1;
        @(posedge clk); #1;
        abort_i = 1'b0;
        check("abort_flag", aborted_o, 1);
        check("abort_err", error_o, 0);
        check("abort_issued", issued_cnt_o, 2);
        finish_test(1);

        // count = 0
        start_cfg(0, 4, 0, 32'h10, 32'h1, 1);
        finish_test(2);
        check("zero_len", acc_log.size(), 0);
        check("zero_done", done_cnt, 1);

        // reset mid-burst
        start_cfg(0, 0, 20, 32'h40, 32'h0, 1);
        @(posedge clk); #3;
        rst_i = 1'b1;
        #1;
        check("mid_rst_valid", cmd_valid_o, 0);
        check("mid_rst_write", cmd_write_o, 0);
        check("mid_rst_addr", cmd_addr_o, 0);
        check("mid_rst_burst", cmd_burst_o, 0);
        check("mid_rst_busy", busy_o, 0);
        check("mid_rst_issued", issued_cnt_o, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_i  = 1'b0;
        busy_i = 1'b0;

        // recovery after reset
        start_cfg(1, 4, 2, 32'h10, 32'h10, 3);
        finish_test(1);
        check("rec_a0", acc_log[0], {1'b0, 32'h10});
        check("rec_a1", acc_log[1], {1'b0, 32'h20});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time limit so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
